// File: rtl/bcpu_bram_pkg.sv
// Shared defaults and elaboration helpers for the bcpu16 memory-port initiator.
// Provides default widths, a legality check for the memory read latency, and
// a ceil(log2) helper used to size credit counters and FIFO pointers.
package bcpu_bram_pkg;

  localparam int unsigned DEF_DATA_WIDTH   = 16;
  localparam int unsigned DEF_ADDR_WIDTH   = 12;
  localparam int unsigned DEF_READ_LATENCY = 2;
  localparam int unsigned DEF_RESP_DEPTH   = 4;

  // Port RAMs exist either without (1) or with (2) an output register.
  function automatic bit read_latency_ok(input int unsigned lat);
    return (lat == 1) || (lat == 2);
  endfunction

  // Bits needed to index n distinct values; never less than 1 so a
  // degenerate size still yields a legal vector.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 31; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcpu_resp_fifo.sv
// Synchronous response FIFO for the memory-port initiator.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   ce          - clock enable; all state holds while low
//   push        - write push_data at the tail (qualified by ce)
//   pop         - drop the head entry (qualified by ce, ignored when empty)
//   head_data   - current head entry, straight from storage
//   count       - number of valid entries, 0..DEPTH
module bcpu_resp_fifo
  import bcpu_bram_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int unsigned DEPTH      = DEF_RESP_DEPTH,
  localparam int unsigned PTR_W      = clog2_min1(DEPTH),
  localparam int unsigned CNT_W      = clog2_min1(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_push, do_pop;

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    do_push  = ce & push;
    do_pop   = ce & pop & (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which
  // entries are meaningful, and an unreset array maps onto plain RAM/regs.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Upstream credit accounting must make this impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(do_push && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/bcpu_bram_initiator.sv
// Initiator for one port of the bcpu16 dual-port program/data RAM.
// Turns a valid/ready request channel into EN/WREN/ADDR/WRDATA strobes with
// zero added latency, tracks the RAM's fixed read latency, and returns read
// data in request order on a backpressured valid/ready response channel.
// Ports:
//   CLK, RESET_N, CE                     - clock, async active-low reset, clock enable
//   REQ_VALID/READY/WREN/ADDR/WRDATA     - request channel from the client
//   RESP_VALID/READY/DATA                - read response channel to the client
//   BUSY                                 - reads in flight or responses queued
//   MEM_EN/WREN/ADDR/WRDATA, MEM_RDDATA  - memory port
module bcpu_bram_initiator
  import bcpu_bram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int unsigned READ_LATENCY = DEF_READ_LATENCY,
  parameter int unsigned RESP_DEPTH   = DEF_RESP_DEPTH
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  CE,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WREN,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_WRDATA,
  output logic                  RESP_VALID,
  input  logic                  RESP_READY,
  output logic [DATA_WIDTH-1:0] RESP_DATA,
  output logic                  BUSY,
  output logic                  MEM_EN,
  output logic                  MEM_WREN,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WRDATA,
  input  logic [DATA_WIDTH-1:0] MEM_RDDATA
);

  localparam int unsigned CRED_W = clog2_min1(RESP_DEPTH + 1);
  localparam int unsigned CNT_W  = clog2_min1(RESP_DEPTH + 1);

  // One bit per cycle of read latency; the MSB marks MEM_RDDATA as valid now.
  logic [READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  // Free FIFO slots not yet promised to an in-flight read.
  logic [CRED_W-1:0]       credits_q, credits_d;
  logic [CNT_W-1:0]        fifo_count;
  logic                    accept, rd_accept, resp_pop;

  always_comb begin
    REQ_READY = RESET_N & CE & (credits_q != '0);
    accept    = REQ_VALID & REQ_READY;
    rd_accept = accept & ~REQ_WREN;
    resp_pop  = RESP_VALID & RESP_READY & CE;

    // A write borrows and returns its slot in the same cycle, so only reads
    // and pops move the counter.
    credits_d = credits_q - CRED_W'(rd_accept) + CRED_W'(resp_pop);
    rd_pipe_d = (rd_pipe_q << 1) | READ_LATENCY'(rd_accept);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_pipe_q <= '0;
      credits_q <= CRED_W'(RESP_DEPTH);
    end else if (CE) begin
      rd_pipe_q <= rd_pipe_d;
      credits_q <= credits_d;
    end
  end

  bcpu_resp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .ce        (CE),
    .push      (rd_pipe_q[READ_LATENCY-1]),
    .push_data (MEM_RDDATA),
    .pop       (resp_pop),
    .head_data (RESP_DATA),
    .count     (fifo_count)
  );

  assign MEM_EN     = accept;
  assign MEM_WREN   = accept & REQ_WREN;
  assign MEM_ADDR   = REQ_ADDR;
  assign MEM_WRDATA = REQ_WRDATA;
  assign RESP_VALID = (fifo_count != '0);
  assign BUSY       = (rd_pipe_q != '0) | RESP_VALID;

  a_latency_legal: assert property (@(posedge CLK) read_latency_ok(READ_LATENCY));
  a_credit_bound:  assert property (@(posedge CLK) disable iff (!RESET_N)
    credits_q <= CRED_W'(RESP_DEPTH));

endmodule

// File: tb/tb_bcpu_bram_initiator.sv
// Self-checking bench for bcpu_bram_initiator with a 2-cycle-latency RAM stub.
// A monitor on the falling edge records accepted requests against a
// transaction-level memory model, queues expected read data, and compares
// every presented response against the queue head.
module tb_bcpu_bram_initiator;

  localparam int DW    = 16;
  localparam int AW    = 12;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          CE = 1'b1;
  logic          REQ_VALID = 1'b0;
  logic          REQ_WREN = 1'b0;
  logic [AW-1:0] REQ_ADDR = '0;
  logic [DW-1:0] REQ_WRDATA = '0;
  logic          RESP_READY = 1'b0;
  logic          REQ_READY, RESP_VALID, BUSY, MEM_EN, MEM_WREN;
  logic [DW-1:0] RESP_DATA, MEM_WRDATA, MEM_RDDATA;
  logic [AW-1:0] MEM_ADDR;

  // RAM stub: registered read plus output register, both stalled by CE.
  logic [DW-1:0] stub_mem [1<<AW];
  logic [DW-1:0] stub_stage, stub_out;

  // Reference model state.
  logic [DW-1:0] ref_mem [1<<AW];
  logic [DW-1:0] exp_q [$];
  int            outstanding = 0;
  int            pops = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  always #5 CLK = ~CLK;

  bcpu_bram_initiator #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .READ_LATENCY (LAT), .RESP_DEPTH (DEPTH)
  ) dut (
    .CLK (CLK), .RESET_N (RESET_N), .CE (CE),
    .REQ_VALID (REQ_VALID), .REQ_READY (REQ_READY), .REQ_WREN (REQ_WREN),
    .REQ_ADDR (REQ_ADDR), .REQ_WRDATA (REQ_WRDATA),
    .RESP_VALID (RESP_VALID), .RESP_READY (RESP_READY), .RESP_DATA (RESP_DATA),
    .BUSY (BUSY),
    .MEM_EN (MEM_EN), .MEM_WREN (MEM_WREN), .MEM_ADDR (MEM_ADDR),
    .MEM_WRDATA (MEM_WRDATA), .MEM_RDDATA (MEM_RDDATA)
  );

  always @(posedge CLK) begin
    if (CE) begin
      if (MEM_EN && MEM_WREN)  stub_mem[MEM_ADDR] <= MEM_WRDATA;
      if (MEM_EN && !MEM_WREN) stub_stage <= stub_mem[MEM_ADDR];
      stub_out <= stub_stage;
    end
  end
  assign MEM_RDDATA = stub_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: request acceptance feeds the model, responses are compared.
  always @(negedge CLK) begin : monitor
    logic exp_rdy;
    exp_rdy = RESET_N && CE && (outstanding < DEPTH);
    check("req_ready", REQ_READY, exp_rdy);
    check("mem_en", MEM_EN, REQ_VALID && exp_rdy);
    check("mem_wren", MEM_WREN, REQ_VALID && exp_rdy && REQ_WREN);
    if (RESET_N && RESP_VALID) begin
      if (exp_q.size() == 0) check("resp_unexpected", 1, 0);
      else check("resp_data", RESP_DATA, exp_q[0]);
      if (CE && RESP_READY) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        outstanding--;
        pops++;
      end
    end
    if (REQ_VALID && exp_rdy) begin
      if (REQ_WREN) ref_mem[REQ_ADDR] = REQ_WRDATA;
      else begin
        exp_q.push_back(ref_mem[REQ_ADDR]);
        outstanding++;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_req(input logic [AW-1:0] a, input logic [DW-1:0] d);
    REQ_VALID = 1'b1; REQ_WREN = 1'b1; REQ_ADDR = a; REQ_WRDATA = d;
    #1;
    for (int k = 0; k < 50 && !REQ_READY; k++) begin
      step();
      #1;
    end
    check("write_accept", REQ_READY, 1);
    step();
    REQ_VALID = 1'b0; REQ_WREN = 1'b0;
  endtask

  task automatic drain();
    CE = 1'b1; REQ_VALID = 1'b0; RESP_READY = 1'b1;
    for (int k = 0; k < 200 && (BUSY || exp_q.size() != 0); k++) step();
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_busy", BUSY, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] bp_val [6];
    int acc, issued, pops_before;

    // Reset state, with a request presented to prove it is ignored.
    REQ_VALID = 1'b1;
    #3;
    check("rst_req_ready", REQ_READY, 0);
    check("rst_mem_en", MEM_EN, 0);
    check("rst_resp_valid", RESP_VALID, 0);
    check("rst_busy", BUSY, 0);
    REQ_VALID = 1'b0;
    step(); step();
    RESET_N = 1'b1;
    step();

    // Single read, cycle-exact latency.
    write_req(12'h010, 16'hBEEF);
    RESP_READY = 1'b1;
    step();
    REQ_VALID = 1'b1; REQ_WREN = 1'b0; REQ_ADDR = 12'h010;
    step();
    REQ_VALID = 1'b0;
    check("single_c1_rv", RESP_VALID, 0);
    check("single_c1_busy", BUSY, 1);
    step();
    check("single_c2_rv", RESP_VALID, 0);
    step();
    check("single_c3_rv", RESP_VALID, 1);
    check("single_c3_data", RESP_DATA, 16'hBEEF);
    step();
    check("single_c4_busy", BUSY, 0);
    check("single_c4_rv", RESP_VALID, 0);

    // Streaming reads at full rate.
    for (int i = 0; i < 8; i++) write_req(AW'(i), DW'(16'h100 + i));
    RESP_READY = 1'b1;
    step();
    for (int c = 0; c < 12; c++) begin
      check("stream_rv", RESP_VALID, (c >= 3 && c <= 10));
      if (c >= 3 && c <= 10) check("stream_data", RESP_DATA, 16'h100 + c - 3);
      if (c < 8) begin
        REQ_VALID = 1'b1; REQ_WREN = 1'b0; REQ_ADDR = AW'(c);
        #1;
        check("stream_ready", REQ_READY, 1);
      end else REQ_VALID = 1'b0;
      step();
    end

    // Backpressure: credits limit acceptance to the FIFO depth.
    for (int i = 0; i < 6; i++) begin
      bp_val[i] = DW'($urandom);
      write_req(AW'(12'h020 + i), bp_val[i]);
    end
    RESP_READY = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      REQ_VALID = 1'b1; REQ_WREN = 1'b0; REQ_ADDR = AW'(12'h020 + i);
      #1;
      if (REQ_READY) acc++;
      step();
    end
    REQ_VALID = 1'b0;
    check("bp_accepted", acc, 4);
    for (int i = 0; i < 4; i++) step();
    check("bp_ready_low", REQ_READY, 0);
    RESP_READY = 1'b1;
    #1;
    check("bp_ready_at_first_pop", REQ_READY, 0);
    for (int k = 0; k < 4; k++) begin
      check("bp_data", RESP_DATA, bp_val[k]);
      step();
      if (k == 0) check("bp_ready_back", REQ_READY, 1);
    end
    check("bp_empty", RESP_VALID, 0);

    // Write then read of the same address on consecutive cycles.
    write_req(12'h0FF, 16'h1111);
    RESP_READY = 1'b1;
    step();
    REQ_VALID = 1'b1; REQ_WREN = 1'b1; REQ_ADDR = 12'h0FF; REQ_WRDATA = 16'h5A5A;
    step();
    REQ_WREN = 1'b0;
    step();
    REQ_VALID = 1'b0;
    check("raw_c2_rv", RESP_VALID, 0);
    step();
    check("raw_c3_rv", RESP_VALID, 0);
    step();
    check("raw_c4_rv", RESP_VALID, 1);
    check("raw_c4_data", RESP_DATA, 16'h5A5A);
    step();

    // Clock-enable stall in the middle of a stream.
    for (int i = 0; i < 6; i++) write_req(AW'(12'h030 + i), DW'($urandom));
    RESP_READY = 1'b1;
    issued = 0;
    pops_before = pops;
    for (int c = 0; c < 20; c++) begin
      CE = !(c >= 3 && c <= 5);
      if (issued < 6) begin
        REQ_VALID = 1'b1; REQ_WREN = 1'b0; REQ_ADDR = AW'(12'h030 + issued);
      end else REQ_VALID = 1'b0;
      #1;
      if (!CE) begin
        check("stall_mem_en", MEM_EN, 0);
        check("stall_ready", REQ_READY, 0);
      end else if (REQ_VALID && REQ_READY) issued++;
      step();
    end
    drain();
    check("stall_all_returned", pops - pops_before, 6);

    // Asynchronous reset with two reads in flight.
    for (int i = 0; i < 6; i++) write_req(AW'(12'h040 + i), DW'($urandom));
    RESP_READY = 1'b0;
    REQ_VALID = 1'b1; REQ_WREN = 1'b0; REQ_ADDR = 12'h040;
    step();
    REQ_ADDR = 12'h041;
    step();
    check("rstmid_busy_before", BUSY, 1);
    REQ_WREN = 1'b1; REQ_ADDR = 12'h050;
    RESET_N = 1'b0;
    #1;
    check("rstmid_req_ready", REQ_READY, 0);
    check("rstmid_mem_en", MEM_EN, 0);
    check("rstmid_mem_wren", MEM_WREN, 0);
    check("rstmid_resp_valid", RESP_VALID, 0);
    check("rstmid_busy", BUSY, 0);
    REQ_VALID = 1'b0; REQ_WREN = 1'b0;
    exp_q.delete();
    outstanding = 0;
    #1;
    RESET_N = 1'b1;
    RESP_READY = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("rstmid_no_stale", RESP_VALID, 0);
    end
    RESP_READY = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      REQ_VALID = 1'b1; REQ_WREN = 1'b0; REQ_ADDR = AW'(12'h040 + i);
      #1;
      if (REQ_READY) acc++;
      step();
    end
    check("rstmid_credits", acc, 4);
    drain();

    // Randomized traffic over a small address window to exercise hazards.
    for (int i = 0; i < 16; i++) write_req(AW'(i), DW'($urandom));
    for (int c = 0; c < 1500; c++) begin
      CE         = ($urandom_range(0, 9) != 0);
      REQ_VALID  = ($urandom_range(0, 9) < 6);
      REQ_WREN   = ($urandom_range(0, 9) < 3);
      REQ_ADDR   = AW'($urandom_range(0, 15));
      REQ_WRDATA = DW'($urandom);
      RESP_READY = ($urandom_range(0, 9) < 7);
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcpu_bram_initiator.md
Name: bcpu_bram_initiator

Overview:
Initiator side of the bcpu16 dual-port memory port protocol. Accepts valid/ready read/write requests from a client (DMA, loader, debug or peripheral master) and drives one memory port (EN/WREN/ADDR/WRDATA). It tracks fixed read latency and captures RDDATA into a response FIFO, so the client receives read data through a backpressured valid/ready channel. Sits between any bus-style master and port A or B of the program/data RAM.

Parameters:
DATA_WIDTH, 16, data word width; must equal the memory's.
ADDR_WIDTH, 12, word address width; must equal the memory's.
READ_LATENCY, 2, cycles from accepted read to valid MEM_RDDATA; legal values 1 (no output reg) or 2 (output reg).
RESP_DEPTH, 4, response FIFO entries; power of two, >= READ_LATENCY+2 for full throughput.

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous reset, active low
CE  in  1  clock enable; tie to the memory's CE
REQ_VALID  in  1  request present
REQ_READY  out  1  request accepted this cycle when REQ_VALID=1
REQ_WREN  in  1  1=write, 0=read
REQ_ADDR  in  ADDR_WIDTH  word address
REQ_WRDATA  in  DATA_WIDTH  write data
RESP_VALID  out  1  read data available
RESP_READY  in  1  client consumes read data
RESP_DATA  out  DATA_WIDTH  read data, in request order
BUSY  out  1  reads in flight or FIFO non-empty
MEM_EN  out  1  to memory port EN
MEM_WREN  out  1  to memory port WREN
MEM_ADDR  out  ADDR_WIDTH  to memory port ADDR
MEM_WRDATA  out  DATA_WIDTH  to memory port WRDATA
MEM_RDDATA  in  DATA_WIDTH  from memory port RDDATA

Behaviour:
- Reset (RESET_N=0, async): in-flight pipeline cleared, FIFO pointers/count = 0, credits = RESP_DEPTH. While reset is asserted: REQ_READY=0, MEM_EN=0, MEM_WREN=0, RESP_VALID=0, BUSY=0. Reads in flight at reset are dropped.
- State advances only when CE=1; CE=0 freezes everything, matching the memory's stall.
- REQ_READY = RESET_N & CE & (credits != 0). It is independent of REQ_VALID/REQ_WREN.
- Accept = REQ_VALID & REQ_READY. MEM_EN=accept and MEM_WREN=accept&REQ_WREN, both combinational. MEM_ADDR and MEM_WRDATA pass through. Zero added request latency.
- Writes consume a credit slot for uniformity. The slot is returned the same cycle, so writes never reduce available credits net. Writes produce no response.
- Read accepted in cycle 0: a valid bit enters a READ_LATENCY-deep shift register (advances on CE). MEM_RDDATA is captured into the FIFO at the end of cycle READ_LATENCY. RESP_VALID rises in cycle READ_LATENCY+1.
- Credit counter width clog2(RESP_DEPTH+1):
  - -1 on read accept.
  - +1 on pop (RESP_VALID & RESP_READY & CE).
  - Simultaneous accept and pop: unchanged.
  - Never underflows (REQ_READY gates it) or exceeds RESP_DEPTH.
- FIFO never overflows by construction. A push to a full FIFO is an assertion failure.
- RESP_DATA = FIFO head (registered storage). RESP_VALID = count != 0. Data is stable while RESP_VALID=1 and not popped.
- Ordering is strict request order. Read-after-write to the same address issued on consecutive cycles returns the new data (single-port serialization).
- BUSY = (shift register != 0) | (FIFO count != 0).
- Full rate: with RESP_READY held 1 and RESP_DEPTH >= READ_LATENCY+2, one read per cycle is sustained.

Decomposition:
- Package bcpu_bram_pkg: default widths, READ_LATENCY legal-value check function, clog2 helper for credit/pointer widths.
- One sub-module bcpu_resp_fifo: synchronous FIFO (DATA_WIDTH, DEPTH) with push/pop/count, async active-low reset, CE-qualified.

Test Plan:
- Single read: preload mem[0x010]=0xBEEF, read 0x010 at cycle 0 (L=2) -> RESP_VALID=1 with 0xBEEF at cycle 3, BUSY low at cycle 4 after pop.
- Streaming: 8 back-to-back reads 0x000..0x007 holding mem[i]=i+0x100, RESP_READY=1 -> REQ_READY never drops, responses 0x100..0x107 on 8 consecutive cycles.
- Backpressure: RESP_READY=0, issue reads -> exactly 4 accepted, then REQ_READY=0. Raise RESP_READY -> data in order, REQ_READY returns the cycle after the first pop.
- Write then read: write 0x5A5A to 0x0FF, read 0x0FF next cycle -> response 0x5A5A, no response for the write.
- CE stall: drop CE for 3 cycles mid-stream -> no MEM_EN, no pops, no data loss. Responses resume in order, each delayed 3 cycles.
- Reset mid-op: 2 reads in flight, pulse RESET_N low between edges -> outputs 0 immediately. After release, credits=4, RESP_VALID stays 0 (no stale data).
